// File: rtl/cfb_pkg.sv
// Shared AES/CFB definitions: block and word widths, FSM states, S-box and Rcon tables,
// and the GF(2^8) doubling helper.
package cfb_pkg;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed by round number minus one.
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES-128 encryption round with on-the-fly key expansion.
// Byte i of a block sits in bits [127-8i -: 8]; bytes are column-major.
module aes_round_comb
    import cfb_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] rkey,
    input  logic [7:0]         rcon,
    input  logic               last_round,
    output logic [BLOCK_W-1:0] state_next,
    output logic [BLOCK_W-1:0] rkey_next
);

    logic [7:0]         sb [16];
    logic [7:0]         sr [16];
    logic [BLOCK_W-1:0] mc;
    logic [WORD_W-1:0]  w3_rot;
    logic [WORD_W-1:0]  sub_rot;
    logic [WORD_W-1:0]  w0_next;
    logic [WORD_W-1:0]  w1_next;
    logic [WORD_W-1:0]  w2_next;
    logic [WORD_W-1:0]  w3_next;

    genvar gi;

    // SubBytes, then ShiftRows: row r of column c takes row r of column (c+r)%4.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub
            assign sb[gi] = SBOX[state[BLOCK_W-1-8*gi -: 8]];
            assign sr[gi] = sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
        end
    endgenerate

    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr[4*gi];
            assign a1 = sr[4*gi+1];
            assign a2 = sr[4*gi+2];
            assign a3 = sr[4*gi+3];
            assign mc[BLOCK_W-1-32*gi -: 32] = last_round ? {a0, a1, a2, a3} :
                {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
    endgenerate

    assign w3_rot = {rkey[23:0], rkey[31:24]};

    generate
        for (gi = 0; gi < 4; gi++) begin : g_ksub
            assign sub_rot[WORD_W-1-8*gi -: 8] = SBOX[w3_rot[WORD_W-1-8*gi -: 8]];
        end
    endgenerate

    assign w0_next = rkey[127:96] ^ sub_rot ^ {rcon, 24'h000000};
    assign w1_next = rkey[95:64]  ^ w0_next;
    assign w2_next = rkey[63:32]  ^ w1_next;
    assign w3_next = rkey[31:0]   ^ w2_next;

    assign rkey_next  = {w0_next, w1_next, w2_next, w3_next};
    assign state_next = mc ^ rkey_next;

endmodule

// File: rtl/cfb_d.sv
// Iterative AES-128 CFB-128 decryptor, one round per clock, with valid/ready on both sides.
// Define CFB_D_BIDIR_EN to add a mode_enc port selecting CFB encryption per block.
module cfb_d
    import cfb_pkg::*;
#(
    parameter int                 NR     = 10,
    parameter logic [BLOCK_W-1:0] RST_IV = '0
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef CFB_D_BIDIR_EN
    input  logic               mode_enc,
`endif
    input  logic               iv_load,
    input  logic [BLOCK_W-1:0] iv,
    input  logic [BLOCK_W-1:0] key,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] ciphertext,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] plaintext,
    output logic               busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t             state_reg, state_next;
    logic [3:0]         rnd_reg, rnd_next;
    logic [BLOCK_W-1:0] fb_reg, fb_next;
    logic [BLOCK_W-1:0] aes_reg, aes_next;
    logic [BLOCK_W-1:0] rkey_reg, rkey_next;
    logic [BLOCK_W-1:0] ct_reg, ct_next;
    logic [BLOCK_W-1:0] pt_reg, pt_next;
    logic               ov_reg, ov_next;
    logic               enc_reg, enc_next;
    logic               in_ready_c;
    logic               accept_enc;
    logic [3:0]         rcon_idx;
    logic [BLOCK_W-1:0] round_state;
    logic [BLOCK_W-1:0] round_key;
    logic               last_round;

`ifdef CFB_D_BIDIR_EN
    assign accept_enc = mode_enc;
`else
    assign accept_enc = 1'b0;
`endif

    assign rcon_idx   = (rnd_reg >= 4'd1 && rnd_reg <= 4'd10) ? rnd_reg - 4'd1 : 4'd0;
    assign last_round = (rnd_reg == LAST_RND);

    aes_round_comb u_round (
        .state      (aes_reg),
        .rkey       (rkey_reg),
        .rcon       (RCON[rcon_idx]),
        .last_round (last_round),
        .state_next (round_state),
        .rkey_next  (round_key)
    );

    always_comb begin
        state_next = state_reg;
        rnd_next   = rnd_reg;
        fb_next    = fb_reg;
        aes_next   = aes_reg;
        rkey_next  = rkey_reg;
        ct_next    = ct_reg;
        pt_next    = pt_reg;
        ov_next    = ov_reg;
        enc_next   = enc_reg;
        in_ready_c = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = !iv_load;
                if (iv_load) begin
                    fb_next = iv;
                end else if (in_valid) begin
                    aes_next   = fb_reg ^ key;
                    rkey_next  = key;
                    ct_next    = ciphertext;
                    enc_next   = accept_enc;
                    // Decryption chains on the received block; encryption waits for its output.
                    if (!accept_enc) fb_next = ciphertext;
                    rnd_next   = 4'd1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                aes_next  = round_state;
                rkey_next = round_key;
                if (last_round) begin
                    pt_next    = ct_reg ^ round_state;
                    ov_next    = 1'b1;
                    state_next = DONE;
                    if (enc_reg) fb_next = ct_reg ^ round_state;
                end else begin
                    rnd_next = rnd_reg + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_next    = 1'b0;
                    rnd_next   = 4'd0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rnd_reg   <= 4'd0;
            fb_reg    <= RST_IV;
            aes_reg   <= '0;
            rkey_reg  <= '0;
            ct_reg    <= '0;
            pt_reg    <= '0;
            ov_reg    <= 1'b0;
            enc_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rnd_reg   <= rnd_next;
            fb_reg    <= fb_next;
            aes_reg   <= aes_next;
            rkey_reg  <= rkey_next;
            ct_reg    <= ct_next;
            pt_reg    <= pt_next;
            ov_reg    <= ov_next;
            enc_reg   <= enc_next;
        end
    end

    assign in_ready  = in_ready_c & rst_n;
    assign out_valid = ov_reg;
    assign plaintext = pt_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_cfb_d.sv
// Directed bench for cfb_d: a scoreboard queue holds expected output blocks, derived from
// SP800-38A constants or from an independent textbook AES model built from GF(2^8) arithmetic.
module tb_cfb_d;

    localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT2 = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT3 = 128'h26751f67a3cbb140b1808cf187a4f4df;
    localparam logic [127:0] CT4 = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv_load = 1'b0;
    logic [127:0] iv = '0;
    logic [127:0] key = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] ciphertext = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] plaintext;
    logic         busy;
`ifdef CFB_D_BIDIR_EN
    logic         mode_enc = 1'b0;
`endif

    int           errors = 0;
    int           checks = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sb [256];

    always #5 clk = ~clk;

    cfb_d dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CFB_D_BIDIR_EN
        .mode_enc   (mode_enc),
`endif
        .iv_load    (iv_load),
        .iv         (iv),
        .key        (key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from the multiplicative inverse followed by the affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] blk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [16];
        logic [7:0]   rc;
        logic [7:0]   t0, t1, t2, t3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = blk[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int rn = 1; rn <= 10; rn++) begin
            t0 = sb[w[13]] ^ rc;
            t1 = sb[w[14]];
            t2 = sb[w[15]];
            t3 = sb[w[12]];
            w[0] = w[0] ^ t0;
            w[1] = w[1] ^ t1;
            w[2] = w[2] ^ t2;
            w[3] = w[3] ^ t3;
            for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
            rc = gmul(rc, 8'h02);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[4*c+q] = sb[s[4*((c+q)%4)+q]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    if (rn != 10)
                        s[4*c+q] = gmul(t[4*c+q], 8'h02) ^ gmul(t[4*c+(q+1)%4], 8'h03) ^
                                   t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
                    else
                        s[4*c+q] = t[4*c+q];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [127:0] blk, input logic [127:0] expv);
        int ok;
        ok = 0;
        ciphertext = blk;
        in_valid = 1'b1;
        #1;
        for (int n = 0; n < 64 && ok == 0; n++) begin
            if (in_ready) begin
                ok = 1;
                exp_q.push_back(expv);
            end
            tick();
        end
        in_valid = 1'b0;
        chk_int({tag, "_accepted"}, ok, 1);
        $display("send %s: block %h", tag, blk);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_out(input string tag);
        logic [127:0] expv;
        chk1({tag, "_out_valid"}, out_valid, 1'b1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        chk128(tag, plaintext, expv);
        $display("recv %s: block %h", tag, plaintext);
    endtask

    task automatic wait_out(input string tag, output int lat);
        wait_valid(lat);
        check_out(tag);
        if (out_ready) tick();
    endtask

    int           lat;
    logic [127:0] exp3;
    logic [127:0] held;

    initial begin
        build_sbox();

        tick();
        tick();
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk128("rst_plaintext", plaintext, 128'h0);
        rst_n = 1'b1;
        tick();

        // iv_load outranks in_valid; the decrypt of block 1 then proves feedback took the iv.
        key = K;
        iv = IV1;
        iv_load = 1'b1;
        in_valid = 1'b1;
        ciphertext = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        #1;
        chk1("prio_in_ready", in_ready, 1'b0);
        tick();
        iv_load = 1'b0;
        in_valid = 1'b0;
        #1;
        chk1("prio_no_accept", busy, 1'b0);

        send("blk1", CT1, PT1);
        wait_out("blk1", lat);
        chk_int("blk1_latency", lat, 10);

        // Chaining, with key/iv/ciphertext disturbed mid-round.
        send("blk2", CT2, PT2);
        tick();
        tick();
        key = ~K;
        iv = ~IV1;
        iv_load = 1'b1;
        ciphertext = ~CT2;
        tick();
        tick();
        tick();
        iv_load = 1'b0;
        key = K;
        iv = IV1;
        wait_out("blk2", lat);

        // Backpressure.
        exp3 = CT3 ^ aes_enc(K, CT2);
        out_ready = 1'b0;
        send("blk3", CT3, exp3);
        wait_valid(lat);
        held = plaintext;
        chk128("bp_first", held, exp3);
        for (int n = 0; n < 20; n++) begin
            tick();
            chk128("bp_stable", plaintext, held);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_busy", busy, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check_out("blk3");
        tick();
        chk1("bp_idle_busy", busy, 1'b0);
        chk1("bp_idle_out_valid", out_valid, 1'b0);

        // Reset while round 5 is in the pipe.
        send("blk4_abort", CT4, 128'h0);
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk128("mid_rst_plaintext", plaintext, 128'h0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send("blk4_fb0", CT4, CT4 ^ aes_enc(K, 128'h0));
        wait_out("blk4_fb0", lat);
        chk_int("blk4_latency", lat, 10);

`ifdef CFB_D_BIDIR_EN
        iv = IV1;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        mode_enc = 1'b1;
        send("enc1", PT1, CT1);
        wait_out("enc1", lat);
        send("enc2", PT2, CT2);
        wait_out("enc2", lat);
        mode_enc = 1'b0;
        send("dec3_after_enc", CT3, exp3);
        wait_out("dec3_after_enc", lat);
`endif

        chk_int("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
